// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//   Shared types for the cache and its memory-side responder.
//   - mem_req_type  : request from the cache to main memory
//                     (addr, data, rw, valid)
//   - mem_data_type : response from main memory back to the cache
//                     (data, ready)
//   - resp_state_e  : state encoding of the main-memory responder
//   - LINE_BYTES    : bytes per cache line (one 128-bit word)
//   - LFSR_TAPS     : Galois tap mask for x^16 + x^14 + x^13 + x^11
//   - fill_pattern  : contents returned for a line that was never written
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BITS  = LINE_BYTES * 8;

    // Right-shifting Galois form: bit 15 <- x^16, and 14/13/11 tap positions
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [31:0]          addr;
        logic [LINE_BITS-1:0] data;
        logic                 rw;
        logic                 valid;
    } mem_req_type;

    typedef struct packed {
        logic [LINE_BITS-1:0] data;
        logic                 ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } resp_state_e;

    // An unwritten line reads back as its own line address repeated four
    // times, which makes stale or misrouted data easy to spot in a dump.
    function automatic logic [LINE_BITS-1:0] fill_pattern(input logic [31:0] addr);
        logic [31:0] line_addr;
        line_addr = addr & 32'hFFFF_FFF0;
        return {4{line_addr}};
    endfunction

endpackage

// File: rtl/mem_lfsr16.sv
// ---------------------------------------------------------------------------
// mem_lfsr16
//   16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11) used to jitter the
//   responder latency.
//   Ports:
//     clk    in   clock, state on rising edge
//     rst_n  in   asynchronous active-low reset, loads seed
//     seed   in   16-bit reset value (must be nonzero)
//     enable in   advance one step on the next rising edge
//     q      out  current LFSR state
// ---------------------------------------------------------------------------
module mem_lfsr16
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    input  logic        enable,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/cache_mem_responder.sv
// ---------------------------------------------------------------------------
// cache_mem_responder
//   Main-memory model sitting behind cache_fsm. Accepts one request at a
//   time, waits a configurable (optionally jittered) number of cycles, then
//   pulses mem_data.ready for one cycle. Writes commit a full 128-bit line;
//   reads return the stored line or, for never-written lines, a fill pattern.
//   After each response one GAP cycle ignores the request bus so that a
//   valid still held by the cache is not taken as a second request.
//   Ports:
//     clk       in   clock, all state on rising edge
//     rst       in   asynchronous active-low reset
//     mem_req   in   request from the cache (addr, data, rw, valid)
//     mem_data  out  response to the cache (data, ready)
//     busy      out  high whenever the responder is not IDLE
//     rd_count  out  accepted reads, saturating at 16'hFFFF
//     wr_count  out  accepted writes, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int          LINE_AW    = 8,
    parameter int          RD_LAT     = 2,
    parameter int          WR_LAT     = 5,
    parameter int          JITTER_MAX = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
)
(
    input  logic         clk,
    input  logic         rst,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data,
    output logic         busy,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);

    localparam int DEPTH   = 2 ** LINE_AW;
    // A zero latency would collapse BUSY; clamp so ready is always at least
    // one cycle after accept.
    localparam int RD_BASE = (RD_LAT < 1) ? 1 : RD_LAT;
    localparam int WR_BASE = (WR_LAT < 1) ? 1 : WR_LAT;
    localparam int JIT_MOD = (JITTER_MAX < 0) ? 1 : JITTER_MAX + 1;

    resp_state_e          state_q,  state_d;
    logic [15:0]          cnt_q,    cnt_d;
    logic [31:0]          addr_q,   addr_d;
    logic [LINE_BITS-1:0] wdata_q,  wdata_d;
    logic                 rw_q,     rw_d;
    logic                 ready_q,  ready_d;
    logic [LINE_BITS-1:0] data_q,   data_d;
    logic [15:0]          rd_cnt_q, rd_cnt_d;
    logic [15:0]          wr_cnt_q, wr_cnt_d;
    logic [DEPTH-1:0]     line_valid_q, line_valid_d;

    logic [LINE_BITS-1:0] store_mem [DEPTH];

    logic [15:0]          lfsr_val;
    logic                 accept;
    logic                 done;
    logic                 commit_wr;
    logic [LINE_AW-1:0]   idx;
    logic [31:0]          jitter;
    logic [31:0]          lat_total;

    // Bits above the line index and the byte offset are dropped, so
    // addresses alias onto the store.
    assign idx       = addr_q[LINE_AW+3:4];
    assign accept    = (state_q == IDLE) && mem_req.valid;
    assign done      = (state_q == BUSY) && (cnt_q == 16'd0);
    assign commit_wr = done && rw_q;

    mem_lfsr16 u_lfsr (
        .clk    (clk),
        .rst_n  (rst),
        .seed   (LFSR_SEED),
        .enable (accept),
        .q      (lfsr_val)
    );

    // The counter holds cycles-remaining-minus-one so that ready lands
    // exactly L cycles after the accepting edge.
    always_comb begin
        jitter    = 32'(lfsr_val) % 32'(JIT_MOD);
        lat_total = (mem_req.rw ? 32'(WR_BASE) : 32'(RD_BASE)) + jitter;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        ready_d      = 1'b0;
        data_d       = data_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        line_valid_d = line_valid_q;

        unique case (state_q)
            IDLE: begin
                if (mem_req.valid) begin
                    addr_d  = mem_req.addr;
                    wdata_d = mem_req.data;
                    rw_d    = mem_req.rw;
                    cnt_d   = 16'(lat_total - 32'd1);
                    if (mem_req.rw) begin
                        if (wr_cnt_q != 16'hFFFF) begin
                            wr_cnt_d = wr_cnt_q + 16'd1;
                        end
                    end else begin
                        if (rd_cnt_q != 16'hFFFF) begin
                            rd_cnt_d = rd_cnt_q + 16'd1;
                        end
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 16'd0) begin
                    ready_d = 1'b1;
                    if (rw_q) begin
                        line_valid_d[idx] = 1'b1;
                        data_d            = wdata_q;
                    end else if (line_valid_q[idx]) begin
                        data_d = store_mem[idx];
                    end else begin
                        data_d = fill_pattern(addr_q);
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RESP: begin
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            addr_q       <= 32'd0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            ready_q      <= 1'b0;
            data_q       <= '0;
            rd_cnt_q     <= 16'd0;
            wr_cnt_q     <= 16'd0;
            line_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            ready_q      <= ready_d;
            data_q       <= data_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            line_valid_q <= line_valid_d;
        end
    end

    // Store has no reset: the line-valid bits alone decide whether its
    // contents are meaningful. Reset forces IDLE, so an abandoned write
    // never reaches this port.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            store_mem[idx] <= wdata_q;
        end
    end

    assign mem_data = '{data: data_q, ready: ready_q};
    assign busy     = (state_q != IDLE);
    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_responder
//   Two responders share clock and reset: dut_a without jitter for exact
//   latency vectors, dut_j with JITTER_MAX=3 for the randomised run.
// ---------------------------------------------------------------------------
module tb_cache_mem_responder;
    import cache_pkg::*;

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
        int           exp_lat;
        logic [127:0] exp_data;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    mem_req_type  req_a, req_j;
    mem_data_type resp_a, resp_j;
    logic         busy_a, busy_j;
    logic [15:0]  rdc_a, wrc_a, rdc_j, wrc_j;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_mem_responder #(.JITTER_MAX(0)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (req_a),
        .mem_data (resp_a),
        .busy     (busy_a),
        .rd_count (rdc_a),
        .wr_count (wrc_a)
    );

    cache_mem_responder #(.JITTER_MAX(3)) dut_j (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (req_j),
        .mem_data (resp_j),
        .busy     (busy_j),
        .rd_count (rdc_j),
        .wr_count (wrc_j)
    );

    function automatic logic [127:0] fill_model(input logic [31:0] a);
        return {a[31:4], 4'h0, a[31:4], 4'h0, a[31:4], 4'h0, a[31:4], 4'h0};
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? resp_j.ready : resp_a.ready;
    endfunction

    function automatic logic [127:0] get_data(input bit sel);
        return sel ? resp_j.data : resp_a.data;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy_j : busy_a;
    endfunction

    task automatic set_req(input bit sel, input mem_req_type r);
        if (sel) req_j = r;
        else     req_a = r;
    endtask

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request: drive at negedge, accept on the next rising edge, then
    // scramble the request fields so only the latched copy can be used.
    // Returns the latency in cycles (0 on timeout), response data, busy
    // just after accept, and ready as seen in the GAP cycle.
    task automatic apply_stimulus(input bit sel, input logic rw,
                                  input logic [31:0] addr, input logic [127:0] data,
                                  output int lat, output logic [127:0] rdata,
                                  output logic busy_acc, output logic ready_gap);
        @(negedge clk);
        set_req(sel, '{addr: addr, data: data, rw: rw, valid: 1'b1});
        @(posedge clk);
        #1;
        busy_acc = get_busy(sel);
        set_req(sel, '{addr: 32'hDEAD_BEEF, data: ~data, rw: ~rw, valid: 1'b0});
        lat   = 0;
        rdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (get_ready(sel)) begin
                lat   = c;
                rdata = get_data(sel);
                break;
            end
        end
        @(posedge clk);
        #1;
        ready_gap = get_ready(sel);
        @(posedge clk);
    endtask

    initial begin
        vec_t         vecs [9];
        int           exp_rd, exp_wr;
        int           lat, base;
        logic [127:0] rdata;
        logic         busy_acc, ready_gap, seen_ready;
        logic [15:0]  ready_mask;
        logic [127:0] cap_data;
        logic [127:0] sb_line [8];
        bit           sb_valid [8];
        int           jexp_rd, jexp_wr;
        logic [31:0]  r0, r1;
        logic [2:0]   li;
        logic         jrw;
        logic [31:0]  jaddr;
        logic [127:0] jdata, jexp;

        vecs[0] = '{1'b0, 32'h0000_0010, 128'h0, 2, 128'h00000010_00000010_00000010_00000010};
        vecs[1] = '{1'b1, 32'h1000_0010, 128'hFACEB00C, 5, 128'hFACEB00C};
        vecs[2] = '{1'b0, 32'h1000_0010, 128'h0, 2, 128'hFACEB00C};
        vecs[3] = '{1'b0, 32'h0000_001F, 128'h0, 2, 128'hFACEB00C};
        vecs[4] = '{1'b0, 32'h1234_5678, 128'h0, 2, 128'h12345670_12345670_12345670_12345670};
        vecs[5] = '{1'b1, 32'hABCD_0030, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 5,
                    128'h01234567_89ABCDEF_FEDCBA98_76543210};
        vecs[6] = '{1'b0, 32'h0000_0030, 128'h0, 2, 128'h01234567_89ABCDEF_FEDCBA98_76543210};
        vecs[7] = '{1'b1, 32'hFFFF_FFF0, {4{32'hFFFF_FFFF}}, 5, {4{32'hFFFF_FFFF}}};
        vecs[8] = '{1'b0, 32'h0000_0FF0, 128'h0, 2, {4{32'hFFFF_FFFF}}};

        rst   = 1'b0;
        req_a = '0;
        req_j = '0;
        exp_rd = 0;
        exp_wr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ready", 128'(resp_a.ready), 128'h0);
        check_output("reset_data",  resp_a.data, 128'h0);
        check_output("reset_busy",  128'(busy_a), 128'h0);
        check_output("reset_rdcnt", 128'(rdc_a), 128'h0);
        check_output("reset_wrcnt", 128'(wrc_a), 128'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);

        // Table-driven single transactions on the fixed-latency responder
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].data,
                           lat, rdata, busy_acc, ready_gap);
            if (vecs[i].rw) exp_wr++;
            else            exp_rd++;
            check_output($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
            check_output($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
            check_output($sformatf("vec%0d_busy", i), 128'(busy_acc), 128'h1);
            check_output($sformatf("vec%0d_gap_ready", i), 128'(ready_gap), 128'h0);
        end
        check_output("table_rdcnt", 128'(rdc_a), 128'(exp_rd));
        check_output("table_wrcnt", 128'(wrc_a), 128'(exp_wr));

        // Write-back then allocate with valid held; rw drops after the ready
        @(negedge clk);
        req_a = '{addr: 32'h0000_0050, data: {4{32'h5555_AAAA}}, rw: 1'b1, valid: 1'b1};
        @(posedge clk);
        ready_mask = '0;
        cap_data   = '0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (resp_a.ready) begin
                ready_mask[c] = 1'b1;
                cap_data      = resp_a.data;
            end
            if (c == 5)  req_a.rw    = 1'b0;
            if (c == 10) req_a.valid = 1'b0;
        end
        exp_wr++;
        exp_rd++;
        check_output("b2b_ready_cycles", 128'(ready_mask), 128'h0420);
        check_output("b2b_read_data", cap_data, {4{32'h5555_AAAA}});
        check_output("b2b_rdcnt", 128'(rdc_a), 128'(exp_rd));
        check_output("b2b_wrcnt", 128'(wrc_a), 128'(exp_wr));

        // Read with valid held: only re-accepted once GAP has passed
        @(negedge clk);
        req_a = '{addr: 32'h0000_0060, data: 128'h0, rw: 1'b0, valid: 1'b1};
        @(posedge clk);
        ready_mask = '0;
        cap_data   = '0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (resp_a.ready) begin
                ready_mask[c] = 1'b1;
                cap_data      = resp_a.data;
            end
            if (c == 9) req_a.valid = 1'b0;
        end
        exp_rd += 2;
        check_output("hold_ready_cycles", 128'(ready_mask), 128'h0084);
        check_output("hold_data", cap_data, {4{32'h0000_0060}});
        check_output("hold_rdcnt", 128'(rdc_a), 128'(exp_rd));

        // Reset in the middle of a write: nothing is committed or answered
        @(negedge clk);
        req_a = '{addr: 32'h2222_0010, data: {4{32'h1357_9BDF}}, rw: 1'b1, valid: 1'b1};
        @(posedge clk);
        #1;
        req_a.valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("midrst_busy",  128'(busy_a), 128'h0);
        check_output("midrst_data",  resp_a.data, 128'h0);
        check_output("midrst_rdcnt", 128'(rdc_a), 128'h0);
        check_output("midrst_wrcnt", 128'(wrc_a), 128'h0);
        seen_ready = resp_a.ready;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen_ready |= resp_a.ready;
        end
        check_output("midrst_no_ready", 128'(seen_ready), 128'h0);
        @(negedge clk);
        rst = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        apply_stimulus(1'b0, 1'b0, 32'h2222_0010, 128'h0, lat, rdata, busy_acc, ready_gap);
        exp_rd++;
        check_output("postrst_lat",  128'(lat), 128'd2);
        check_output("postrst_data", rdata, {4{32'h2222_0010}});
        check_output("postrst_rdcnt", 128'(rdc_a), 128'(exp_rd));

        // Randomised run on the jittered responder against a line scoreboard
        jexp_rd = 0;
        jexp_wr = 0;
        for (int k = 0; k < 8; k++) begin
            sb_valid[k] = 1'b0;
            sb_line[k]  = '0;
        end
        for (int n = 0; n < 200; n++) begin
            r0    = $urandom;
            r1    = $urandom;
            li    = r1[6:4];
            jrw   = r1[0];
            jaddr = {r0[31:12], 5'b00000, li, r1[11:8]};
            jdata = {$urandom, $urandom, $urandom, $urandom};
            if (jrw) begin
                jexp = jdata;
                sb_line[li]  = jdata;
                sb_valid[li] = 1'b1;
                jexp_wr++;
            end else begin
                jexp = sb_valid[li] ? sb_line[li] : fill_model(jaddr);
                jexp_rd++;
            end
            base = jrw ? 5 : 2;
            apply_stimulus(1'b1, jrw, jaddr, jdata, lat, rdata, busy_acc, ready_gap);
            checks++;
            if (lat < base || lat > base + 3) begin
                failures++;
                $display("[TB] FAIL jit%0d_lat: got %0d expected %0d..%0d", n, lat, base, base + 3);
            end
            check_output($sformatf("jit%0d_data", n), rdata, jexp);
        end
        check_output("jit_rdcnt", 128'(rdc_j), 128'(jexp_rd));
        check_output("jit_wrcnt", 128'(wrc_j), 128'(jexp_wr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
